// File: rtl/dbus_arbiter_if.sv
// Requester and bus-controller signal bundle for dbus_arbiter.
// The arbiter takes the slave view; the surrounding core/controller takes the master view.
interface dbus_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic        done0, done1;
    logic        err;
    logic [31:0] rdata;
    logic        bus_rd, bus_wd;
    logic [1:0]  bus_size_in, bus_size_out;
    logic [31:0] bus_addr_in, bus_addr_out;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_ready, bus_busy;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
        input  bus_data_out, bus_ready, bus_busy,
        output gnt0, gnt1, done0, done1, err, rdata,
        output bus_rd, bus_wd, bus_size_in, bus_size_out, bus_addr_in, bus_addr_out, bus_data_in
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
        output bus_data_out, bus_ready, bus_busy,
        input  gnt0, gnt1, done0, done1, err, rdata,
        input  bus_rd, bus_wd, bus_size_in, bus_size_out, bus_addr_in, bus_addr_out, bus_data_in
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-port round-robin arbiter/sequencer for the data bus controller (port 0 fetch, port 1 LSU).
// Define DBUS_ARBITER_TIMEOUT_EN to abort a busy-stalled WAIT after TIMEOUT_CYCLES with err=1.
module dbus_arbiter #(
    parameter int BUS_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input logic           clk,
    input logic           rst,
    dbus_arbiter_if.slave dif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam int SAT_I = (TIMEOUT_CYCLES > BUS_LATENCY) ? TIMEOUT_CYCLES : BUS_LATENCY;
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(SAT_I);
    localparam logic [CNT_WIDTH-1:0] LAT_M1  = CNT_WIDTH'(BUS_LATENCY - 1);
`ifdef DBUS_ARBITER_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TO_M1   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 owner, last_owner, we_q;
    logic [31:0]          rdata_q, rdata_nxt;
    logic                 start, pick, norm_exit, tmo, finish;
    logic                 sel_we;
    logic [1:0]           sel_size;
    logic [31:0]          sel_addr, sel_wdata;

    always_comb begin
        // rst gating keeps gnt low while reset is held even though IDLE is decoded
        start     = (state == IDLE) && rst && (dif.req0 || dif.req1)
                    && dif.bus_ready && !dif.bus_busy;
        pick      = (dif.req0 && dif.req1) ? ~last_owner : dif.req1;
        sel_we    = pick ? dif.we1    : dif.we0;
        sel_size  = pick ? dif.size1  : dif.size0;
        if (sel_size == 2'b11) sel_size = 2'b10;
        sel_addr  = pick ? dif.addr1  : dif.addr0;
        sel_wdata = pick ? dif.wdata1 : dif.wdata0;
        norm_exit = (state == WAIT) && (cnt >= LAT_M1) && !dif.bus_busy;
`ifdef DBUS_ARBITER_TIMEOUT_EN
        tmo       = (state == WAIT) && !norm_exit && (cnt >= TO_M1);
`else
        tmo       = 1'b0;
`endif
        finish    = norm_exit || tmo;
        rdata_nxt = rdata_q;
        if (tmo)                      rdata_nxt = '0;
        else if (norm_exit && !we_q)  rdata_nxt = dif.bus_data_out;
    end

    assign dif.gnt0  = start && !pick;
    assign dif.gnt1  = start && pick;
    assign dif.done0 = finish && !owner;
    assign dif.done1 = finish && owner;
    assign dif.err   = tmo;
    assign dif.rdata = rdata_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            owner            <= 1'b0;
            last_owner       <= 1'b1;
            we_q             <= 1'b0;
            rdata_q          <= '0;
            dif.bus_rd       <= 1'b0;
            dif.bus_wd       <= 1'b0;
            dif.bus_size_in  <= '0;
            dif.bus_size_out <= '0;
            dif.bus_addr_in  <= '0;
            dif.bus_addr_out <= '0;
            dif.bus_data_in  <= '0;
        end else begin
            rdata_q <= rdata_nxt;
            case (state)
                IDLE: if (start) begin
                    owner            <= pick;
                    last_owner       <= pick;
                    we_q             <= sel_we;
                    dif.bus_rd       <= !sel_we;
                    dif.bus_wd       <= sel_we;
                    dif.bus_addr_in  <= sel_addr;
                    dif.bus_addr_out <= sel_addr;
                    dif.bus_size_in  <= sel_we ? sel_size : 2'b00;
                    dif.bus_size_out <= sel_we ? 2'b00 : sel_size;
                    dif.bus_data_in  <= sel_we ? sel_wdata : 32'h0;
                    state            <= ISSUE;
                end
                ISSUE: begin
                    dif.bus_rd <= 1'b0;
                    dif.bus_wd <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt < CNT_SAT) cnt <= cnt + 1'b1;
                    if (finish) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data bus controller: port 0 is instruction fetch, port 1 is the load/store unit.
- Accepts one transaction at a time, round-robin between simultaneous requesters, and drives the controller's rd/wd strobes, size and address lines.
- Waits the fixed bus latency plus any busy stall, then returns read data with a one-cycle done pulse.

Parameters:
- BUS_LATENCY, 1, cycles from issue strobe to bus_data_out valid (>=1).
- TIMEOUT_CYCLES, 16, busy-stall limit in WAIT before abort (only with the macro).
- CNT_WIDTH, 5, width of the latency/timeout counter; must hold max(BUS_LATENCY, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  transaction request; held until gnt.
- we0, we1  in  1 each  1=write, 0=read.
- size0, size1  in  2 each  00 byte, 01 half, 10 word; 11 treated as word.
- addr0, addr1  in  32 each  byte address.
- wdata0, wdata1  in  32 each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted, inputs latched.
- done0, done1  out  1 each  one-cycle pulse: transaction complete.
- err  out  1  valid with done; 1 = aborted by timeout.
- rdata  out  32  read data, valid in the done cycle, held until the next done.
- bus_rd, bus_wd  out  1 each  controller read/write strobes.
- bus_size_in, bus_size_out  out  2 each  write and read size to the controller.
- bus_addr_in, bus_addr_out  out  32 each  write and read address.
- bus_data_in  out  32  write data to the controller.
- bus_data_out  in  32  read data from the controller.
- bus_ready  in  1  controller ready.
- bus_busy  in  1  controller busy.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counter 0, last_owner=1 (port 0 wins the first tie). Any in-flight transaction is dropped with no done pulse.
- IDLE:
  - Leaves only if (req0|req1) & bus_ready & !bus_busy.
  - Owner: sole requester; on a tie, the port != last_owner.
  - Latch owner's we/size/addr/wdata, pulse gnt<owner>, last_owner<=owner, go ISSUE.
  - A request arriving during any non-IDLE state waits; no gnt.
- ISSUE (exactly 1 cycle):
  - Write: assert bus_wd, bus_addr_in=addr, bus_size_in=size, bus_data_in=wdata.
  - Read: assert bus_rd, bus_addr_out=addr, bus_size_out=size.
  - Both address buses carry the latched address regardless of direction; the unused size port is 0.
  - Counter <= 0. Go WAIT.
- WAIT:
  - Strobes low; address, size and data held stable.
  - Counter increments each cycle, saturating.
  - Exit when counter >= BUS_LATENCY-1 and !bus_busy.
  - On exit: read captures bus_data_out into rdata; write leaves rdata unchanged. Pulse done<owner>, err=0, go IDLE.
- Back-to-back: earliest next gnt is the cycle after done. Minimum transaction is 3 cycles (gnt, issue, done) for BUS_LATENCY=1.
- Fairness: two continuously requesting ports alternate strictly 0,1,0,1.
- The requester may change inputs after its gnt; the latched copy is used.
- gnt0/gnt1 and done0/done1 are never high together. gnt and done are never high in the same cycle.

Optional Feature:
- Macro: DBUS_ARBITER_TIMEOUT_EN.
- Defined:
  - In WAIT, the counter also counts cycles with bus_busy=1.
  - When it reaches TIMEOUT_CYCLES: pulse done<owner> with err=1, rdata<=0, go IDLE.
  - A timeout and a normal exit in the same cycle resolve as normal exit.
- Undefined: WAIT exits only on the normal condition (may stall forever); err is constant 0.

Test Plan:
- Reset: hold rst=0 with req0=1 -> all outputs 0, no gnt. Release -> gnt0 in the first IDLE cycle with bus_ready=1.
- Single read, port 1: addr1=0x00000104, size1=10, bus_data_out=0xDEADBEEF, BUS_LATENCY=1.
  - Expected: gnt1 at T, bus_rd at T+1 with bus_addr_out=0x104 and bus_size_out=10.
  - Expected: done1 at T+2 with rdata=0xDEADBEEF and err=0.
- Single write, port 0: addr0=0x00000200, size0=00, wdata0=0x000000A5 -> one-cycle bus_wd with bus_addr_in=0x200, bus_size_in=00, bus_data_in=0xA5; done0 two cycles after gnt0; rdata unchanged.
- Tie and fairness: req0=req1=1 held for 4 transactions -> grant order 0,1,0,1; never two gnt or two done in one cycle.
- Busy stall: bus_busy=1 for 5 cycles in WAIT -> done delayed until the cycle after busy falls; address held stable throughout; a new req0 arriving mid-stall gets no gnt until after done.
- With DBUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, bus_busy stuck at 1 -> done with err=1 and rdata=0 on the 16th WAIT cycle, then the next request is granted. Mid-WAIT rst=0 -> no done, outputs 0 immediately.
